// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register file: NUM_REGS x DATA_WIDTH registers with byte strobes, read-only status slots, SLVERR when out of range.
// Latency: B is valid 1 cycle after the later of the AW/W handshakes; R is valid 1 cycle after the AR handshake.
// Backpressure: one write in flight, AW/W readies drop while their buffer is full or B is pending; AR stalls while R is pending.
`timescale 1ns/1ps
module axi4lite_regfile_slave #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 6,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFS_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFS_W;
    // One extra bit so NUM_REGS == 2**IDX_W still compares correctly.
    localparam logic [IDX_W:0] NUM_REGS_W  = (IDX_W+1)'(NUM_REGS);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    logic                                rdy_en;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic                                aw_full, w_full;
    logic [IDX_W-1:0]                    aw_idx_q;
    logic [DATA_WIDTH-1:0]               w_dat_q;
    logic [STRB_W-1:0]                   w_strb_q;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_dat, rd_val;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_in_range, rd_in_range;
    logic                  unused_addr_ofs;

    assign s_axi_awready = rdy_en & ~aw_full & ~s_axi_bvalid;
    assign s_axi_wready  = rdy_en & ~w_full & ~s_axi_bvalid;
    assign s_axi_arready = rdy_en & ~s_axi_rvalid;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // Address and data may each come from the buffer or from this cycle's handshake.
    assign wr_idx      = aw_full ? aw_idx_q : s_axi_awaddr[ADDR_WIDTH-1:OFS_W];
    assign wr_dat      = w_full ? w_dat_q : s_axi_wdata;
    assign wr_strb     = w_full ? w_strb_q : s_axi_wstrb;
    assign commit      = (aw_full | aw_hs) & (w_full | w_hs);
    assign wr_in_range = {1'b0, wr_idx} < NUM_REGS_W;

    assign rd_idx      = s_axi_araddr[ADDR_WIDTH-1:OFS_W];
    assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_W;

    assign unused_addr_ofs = ^{s_axi_awaddr[OFS_W-1:0], s_axi_araddr[OFS_W-1:0]};
    assign reg_q           = regs;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i))
                rd_val = RO_MASK[i] ? ro_data[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) rdy_en <= 1'b0;
        else                rdy_en <= 1'b1;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx_q <= '0;
            w_dat_q  <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:OFS_W];
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_dat_q  <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
        end
    end

    // Read-only slots are never written, so their reg_q slices stay at reset value.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            regs <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_dat[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else if (commit) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_val;
            s_axi_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Bench for axi4lite_regfile_slave: directed scenarios plus randomized traffic against a word-array model,
// with B/R responses checked by a scoreboard monitor on the falling edge.
`timescale 1ns/1ps
module tb_axi4lite_regfile_slave;
    localparam int            DW  = 32;
    localparam int            AW  = 7;
    localparam int            NR  = 16;
    localparam logic [NR-1:0] ROM = 16'h0004;

    logic              s_axi_aclk = 1'b0;
    logic              s_axi_aresetn = 1'b0;
    logic [AW-1:0]     s_axi_awaddr = '0;
    logic              s_axi_awvalid = 1'b0;
    logic              s_axi_awready;
    logic [DW-1:0]     s_axi_wdata = '0;
    logic [DW/8-1:0]   s_axi_wstrb = '0;
    logic              s_axi_wvalid = 1'b0;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready = 1'b0;
    logic [AW-1:0]     s_axi_araddr = '0;
    logic              s_axi_arvalid = 1'b0;
    logic              s_axi_arready;
    logic [DW-1:0]     s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready = 1'b0;
    logic [NR*DW-1:0]  reg_q;
    logic [NR*DW-1:0]  ro_data;

    axi4lite_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(ROM)) dut (
        .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .reg_q(reg_q), .ro_data(ro_data)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model [NR];
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endfunction

    // Word-array reference: returns the bresp the write should earn and applies it.
    function automatic logic [1:0] model_write(input logic [AW-1:0] addr, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx = int'(addr) / 4;
        if (idx >= NR) return 2'b10;
        if (ROM[idx]) return 2'b00;
        for (int b = 0; b < 4; b++)
            if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [AW-1:0] addr);
        int idx = int'(addr) / 4;
        if (idx >= NR) return {32'h0, 2'b10};
        if (ROM[idx]) return {ro_data[idx*32 +: 32], 2'b00};
        return {model[idx], 2'b00};
    endfunction

    // Scoreboard monitor: a handshake is seen here on the falling edge before the rising edge completes it.
    always @(negedge s_axi_aclk) begin
        if (s_axi_aresetn && s_axi_bvalid && s_axi_bready) begin
            if (exp_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_unexpected: got bresp %0h expected no response", s_axi_bresp);
            end else begin
                check("bresp", {62'h0, s_axi_bresp}, {62'h0, exp_b.pop_front()});
            end
        end
        if (s_axi_aresetn && s_axi_rvalid && s_axi_rready) begin
            if (exp_r.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL r_unexpected: got rdata %0h expected no response", s_axi_rdata);
            end else begin
                logic [33:0] e;
                e = exp_r.pop_front();
                check("rdata", {32'h0, s_axi_rdata}, {32'h0, e[33:2]});
                check("rresp", {62'h0, s_axi_rresp}, {62'h0, e[1:0]});
            end
        end
    end

    // Tasks start and end just after a rising edge.
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit finish);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0;
        logic [1:0] resp;
        resp = model_write(addr, data, strb);
        exp_b.push_back(resp);
        while (!(aw_done && w_done)) begin
            s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_awaddr  = addr;
            s_axi_wvalid  = !w_done && (cyc >= w_dly);
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            @(negedge s_axi_aclk);
            hs_aw = s_axi_awvalid && s_axi_awready;
            hs_w  = s_axi_wvalid && s_axi_wready;
            @(posedge s_axi_aclk); #1;
            aw_done |= hs_aw;
            w_done  |= hs_w;
            cyc++;
            if (cyc > 50) begin
                n_cmp++; n_err++;
                $display("FAIL write_timeout: got aw_done=%0d w_done=%0d expected both 1", aw_done, w_done);
                break;
            end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) return;
        check("b_latency", {63'h0, s_axi_bvalid}, 64'h1);
        for (int k = 0; k < b_dly; k++) begin
            @(negedge s_axi_aclk);
            check("hold_bvalid", {63'h0, s_axi_bvalid}, 64'h1);
            check("hold_awready", {63'h0, s_axi_awready}, 64'h0);
            check("hold_wready", {63'h0, s_axi_wready}, 64'h0);
            check("hold_bresp", {62'h0, s_axi_bresp}, {62'h0, resp});
        end
        if (b_dly > 0) begin @(posedge s_axi_aclk); #1; end
        if (finish) begin
            s_axi_bready = 1'b1;
            @(posedge s_axi_aclk); #1;
            s_axi_bready = 1'b0;
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int r_dly);
        bit hs = 0;
        int cyc = 0;
        exp_r.push_back(model_read(addr));
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!hs) begin
            @(negedge s_axi_aclk);
            hs = s_axi_arready;
            @(posedge s_axi_aclk); #1;
            cyc++;
            if (cyc > 50) begin
                n_cmp++; n_err++;
                $display("FAIL read_timeout: got arready=0 expected 1");
                break;
            end
        end
        s_axi_arvalid = 1'b0;
        if (!hs) return;
        check("r_latency", {63'h0, s_axi_rvalid}, 64'h1);
        repeat (r_dly) begin @(posedge s_axi_aclk); #1; end
        s_axi_rready = 1'b1;
        @(posedge s_axi_aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NR; i++)
            check(name, {32'h0, reg_q[i*32 +: 32]}, {32'h0, model[i]});
    endtask

    task automatic reset_wait();
        repeat (2) begin @(posedge s_axi_aclk); #1; end
        s_axi_aresetn = 1'b1;
        check("rdy_before_edge", {63'h0, s_axi_awready}, 64'h0);
        @(posedge s_axi_aclk); #1;
        check("awready_after_rst", {63'h0, s_axi_awready}, 64'h1);
        check("wready_after_rst", {63'h0, s_axi_wready}, 64'h1);
        check("arready_after_rst", {63'h0, s_axi_arready}, 64'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) ro_data[i*32 +: 32] = $urandom;
        ro_data[2*32 +: 32] = 32'hCAFE0001;
        model_clear();

        #1;
        check("rst_bvalid", {63'h0, s_axi_bvalid}, 64'h0);
        check("rst_rvalid", {63'h0, s_axi_rvalid}, 64'h0);
        check("rst_rdata", {32'h0, s_axi_rdata}, 64'h0);
        check("rst_arready", {63'h0, s_axi_arready}, 64'h0);
        check("rst_regq", {63'h0, (reg_q == '0)}, 64'h1);
        reset_wait();

        for (int i = 0; i < NR; i++) do_read(AW'(i*4), 0);

        do_write(7'h04, 32'hDEADBEEF, 4'hF, 0, 3, 0, 1);
        do_read(7'h04, 1);
        do_write(7'h04, 32'h11223344, 4'b0101, 1, 0, 0, 1);
        check("strb_merge", {32'h0, reg_q[63:32]}, 64'hDE22BE44);
        do_read(7'h05, 0);

        do_write(7'h3C, 32'h5A5A0F0F, 4'hF, 0, 0, 0, 1);
        do_write(7'h40, 32'h12345678, 4'hF, 2, 0, 1, 1);
        do_read(7'h40, 0);
        do_read(7'h7F, 2);
        check_regs("oob_regs");

        do_write(7'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1);
        do_read(7'h08, 0);
        check("ro_regq", {32'h0, reg_q[95:64]}, 64'h0);
        do_write(7'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 1);
        check("strb0", {32'h0, reg_q[159:128]}, 64'h0);

        for (int n = 0; n < 80; n++) begin
            int idx;
            logic [AW-1:0] a;
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            a = AW'(idx * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1);
            else
                do_read(a, int'($urandom_range(0, 2)));
        end
        check_regs("rand_regs");

        do_write(7'h0C, 32'hA5A5C3C3, 4'hF, 0, 0, 5, 0);
        check("pre_rst_reg3", {32'h0, reg_q[127:96]}, 64'hA5A5C3C3);
        s_axi_aresetn = 1'b0;
        #1;
        check("midrst_bvalid", {63'h0, s_axi_bvalid}, 64'h0);
        check("midrst_regq", {63'h0, (reg_q == '0)}, 64'h1);
        check("midrst_awready", {63'h0, s_axi_awready}, 64'h0);
        exp_b.delete();
        model_clear();
        reset_wait();
        do_read(7'h0C, 0);
        do_write(7'h00, 32'h0BADF00D, 4'hF, 1, 1, 0, 1);
        do_read(7'h00, 0);

        repeat (3) begin @(posedge s_axi_aclk); #1; end
        check("exp_b_empty", 64'(exp_b.size()), 64'h0);
        check("exp_r_empty", 64'(exp_r.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
